// File: rtl/debouncer_entradas.sv
// Three-channel input debouncer feeding the a/b/c combinational logic; evento strobes on any level change.
// Optional DEBOUNCE_SYNC2FF_EN adds a two-flop synchronizer per raw input (+2 cycles latency).
module debouncer_entradas #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  input  logic c_raw,
  output logic a,
  output logic b,
  output logic c,
  output logic evento
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    w_raw;
  logic [2:0]    w_s;
  logic [2:0]    r_o;
  logic [2:0]    w_o_nxt;
  logic [2:0]    w_flip;
  logic          r_evento;
  logic [CW-1:0] r_cnt     [3];
  logic [CW-1:0] w_cnt_nxt [3];

  assign w_raw = {c_raw, b_raw, a_raw};

`ifdef DEBOUNCE_SYNC2FF_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = w_raw;
`endif

  // A matching sample clears the count, so any run shorter than DEBOUNCE_CYCLES is dropped.
  always_comb begin
    w_o_nxt = r_o;
    w_flip  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_s[i] != r_o[i]) begin
        if (r_cnt[i] == LIMIT) begin
          w_o_nxt[i] = w_s[i];
          w_flip[i]  = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o      <= '0;
      r_evento <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_o      <= w_o_nxt;
      r_evento <= |w_flip;
      for (int unsigned i = 0; i < 3; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign a      = r_o[0];
  assign b      = r_o[1];
  assign c      = r_o[2];
  assign evento = r_evento;

endmodule

// File: tb/tb_debouncer_entradas.sv
// Scoreboard bench for debouncer_entradas: stimulus queues expected {a,b,c,evento} per edge, monitor compares.
module tb_debouncer_entradas;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic c_raw = 1'b0;
  logic a, b, c, evento;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  debouncer_entradas #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .c_raw  (c_raw),
    .a      (a),
    .b      (b),
    .c      (c),
    .evento (evento)
  );

  always #5 clk = ~clk;

  // Drive inputs for the next edge and queue the outputs expected right after it.
  task automatic cyc(input logic r, input logic [2:0] raw_abc, input logic [3:0] exp_abce,
                     input string name);
    exp_t e;
    rst   = r;
    a_raw = raw_abc[2];
    b_raw = raw_abc[1];
    c_raw = raw_abc[0];
    e.name = name;
    e.exp  = exp_abce;
    sb.push_back(e);
    @(posedge clk);
    #4;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {a, b, c, evento};
        n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: abc_evento got %b, required %b at %0t", e.name, got, e.exp, $time);
        end
      end
    end
  end

  initial begin : stimulus
`ifdef DEBOUNCE_SYNC2FF_EN
    cyc(1, 3'b000, 4'b0000, "sync_rst");
    cyc(1, 3'b000, 4'b0000, "sync_rst");
    for (int i = 1; i <= 5; i++) cyc(0, 3'b100, 4'b0000, "sync_a_wait");
    cyc(0, 3'b100, 4'b1001, "sync_a_rise_e6");
    cyc(0, 3'b100, 4'b1000, "sync_a_hold");
    cyc(0, 3'b100, 4'b1000, "sync_a_hold");
`else
    // Reset with all raw inputs high: outputs and evento must stay low.
    cyc(1, 3'b111, 4'b0000, "rst_raw_high");
    cyc(1, 3'b111, 4'b0000, "rst_raw_high");
    cyc(1, 3'b000, 4'b0000, "rst_raw_low");
    cyc(0, 3'b000, 4'b0000, "idle");

    // a rises, held: flips at edge 4 with evento aligned.
    for (int i = 1; i <= 3; i++) cyc(0, 3'b100, 4'b0000, "a_count");
    cyc(0, 3'b100, 4'b1001, "a_rise_e4");
    cyc(0, 3'b100, 4'b1000, "a_evento_drop");
    cyc(0, 3'b100, 4'b1000, "a_hold");

    // b glitch of 3 edges is rejected.
    for (int i = 1; i <= 3; i++) cyc(0, 3'b110, 4'b1000, "b_glitch3");
    for (int i = 1; i <= 3; i++) cyc(0, 3'b100, 4'b1000, "b_glitch_gone");

    // b held 4 edges is accepted, then falls back after 4 low edges.
    for (int i = 1; i <= 3; i++) cyc(0, 3'b110, 4'b1000, "b_count");
    cyc(0, 3'b110, 4'b1101, "b_rise_e4");
    cyc(0, 3'b110, 4'b1100, "b_hold");
    for (int i = 1; i <= 3; i++) cyc(0, 3'b100, 4'b1100, "b_fall_count");
    cyc(0, 3'b100, 4'b1001, "b_fall_e4");
    cyc(0, 3'b100, 4'b1000, "b_low");

    // b and c together: one single-cycle evento.
    for (int i = 1; i <= 3; i++) cyc(0, 3'b111, 4'b1000, "bc_count");
    cyc(0, 3'b111, 4'b1111, "bc_rise_e4");
    cyc(0, 3'b111, 4'b1110, "bc_hold");
    cyc(0, 3'b111, 4'b1110, "bc_hold");

    // Back-to-back flips keep evento high on consecutive cycles.
    cyc(0, 3'b011, 4'b1110, "a_fall_c1");
    cyc(0, 3'b001, 4'b1110, "a_fall_c2_b_c1");
    cyc(0, 3'b001, 4'b1110, "a_fall_c3_b_c2");
    cyc(0, 3'b001, 4'b0111, "a_fall_e4");
    cyc(0, 3'b001, 4'b0011, "b_fall_e4_back2back");
    cyc(0, 3'b001, 4'b0010, "quiet");

    // Reset mid-count on c discards progress.
    cyc(1, 3'b000, 4'b0000, "rst_clear");
    cyc(0, 3'b001, 4'b0000, "c_count1");
    cyc(1, 3'b001, 4'b0000, "c_rst_mid");
    for (int i = 1; i <= 3; i++) cyc(0, 3'b001, 4'b0000, "c_recount");
    cyc(0, 3'b001, 4'b0011, "c_rise_e4");
    cyc(0, 3'b001, 4'b0010, "c_hold");
`endif
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #100000;
    join_any
    disable fork;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: stimulus done %0d, required 1", done);
    end
    #20;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer_entradas.md
# debouncer_entradas

Input-conditioning stage for the three-input combinational logic circuits (inputs `a`, `b`, `c`). It takes three raw push-button/switch levels and debounces each channel independently. It drives clean registered levels `a`, `b`, `c` straight into the downstream logic circuit. A one-cycle `evento` strobe marks every cycle in which any conditioned level changes.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples required before a channel output flips; legal range ≥1.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a_raw`  input  1  raw, possibly bouncing level for channel a.
- `b_raw`  input  1  raw level for channel b.
- `c_raw`  input  1  raw level for channel c.
- `a`  output  1  debounced, registered level for channel a.
- `b`  output  1  debounced level for channel b.
- `c`  output  1  debounced level for channel c.
- `evento`  output  1  registered pulse, high for exactly one cycle when any of `a`/`b`/`c` changed at the preceding edge.

## Operation
- Each channel is identical and independent, with a sample `s`, a registered output `o` and a counter `cnt`.
  - `cnt` is $clog2(DEBOUNCE_CYCLES+1) bits wide and saturates by construction, never wrapping.
- Per-channel states:
  - ESTAVEL (`cnt`==0).
  - CONTANDO (`cnt`>0).
- Transitions at each edge, rst low:
  - `s`==`o`: `cnt`←0 and the channel returns to ESTAVEL. Any partial count is discarded, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - `s`!=`o` and `cnt`<DEBOUNCE_CYCLES-1: `cnt`←`cnt`+1 and the channel is in CONTANDO.
  - `s`!=`o` and `cnt`==DEBOUNCE_CYCLES-1: `o`←`s`, `cnt`←0, and the channel returns to ESTAVEL.
- DEBOUNCE_CYCLES==1: the output copies the sample at every edge where they differ, i.e. a plain register.
- `evento` ← OR over the three channels of "`o` flips at this edge".
  - Simultaneous flips on several channels give a single one-cycle pulse.
  - Flips at back-to-back edges keep `evento` high for consecutive cycles.
- Reset: while `rst` is high at an edge, `a`=`b`=`c`=0, all `cnt`=0, `evento`=0, and synchronizer flops (if present) are 0.
  - Reset mid-count discards all progress.
  - After release, a full DEBOUNCE_CYCLES run of differing samples is required.

## Timing
- Latency, macro off: `s` is the raw input at the edge.
  - A raw level change before edge 1 that is held stable updates the output at edge DEBOUNCE_CYCLES.
  - `evento` is high in the same cycle the new level first appears (after edge DEBOUNCE_CYCLES), so the two are aligned.
- Latency, macro on: add 2 edges (DEBOUNCE_CYCLES+2).
- A bounce that returns to the old level at or before the DEBOUNCE_CYCLES-th sample produces no output change and no `evento`.
- All outputs come directly from flops; there is no combinational path from any input to any output.

## Configuration
- `DEBOUNCE_SYNC2FF_EN` defined: each raw input passes through a two-flop synchronizer (reset to 0) before forming `s`. This is safe for asynchronous physical buttons and adds 2 cycles of latency.
- `DEBOUNCE_SYNC2FF_EN` undefined: `s` is the raw input sampled directly. This is for inputs already synchronous to `clk`, with 2 fewer flops per channel.
- Both builds are functionally identical apart from the latency offset.

## Test plan
(DEBOUNCE_CYCLES=4, macro undefined unless stated)
- `rst`=1 for 2 edges with all raw inputs at 1 -> `a`=`b`=`c`=0 and `evento`=0 throughout the reset.
- `a_raw` 0→1 before edge 1 and held -> `a`=1 after edge 4; `evento`=1 only during the cycle after edge 4; `b`, `c` stay 0.
- `b_raw` high for 3 edges, then low -> `b` stays 0 and `evento` is never asserted. Repeat with 4 edges high -> `b`=1 after edge 4.
- `b_raw` and `c_raw` rise together and are held -> `b`, `c` both rise after edge 4 with a single one-cycle `evento`; the downstream circuit then sees `b`=`c`=1.
- `c_raw` 0→1, `rst` pulsed at edge 2, released -> `c`=0 until 4 more differing edges after release, then `c`=1 with `evento`.
- `DEBOUNCE_SYNC2FF_EN` defined, `a_raw` 0→1 before edge 1 -> `a`=1 and `evento` after edge 6, not earlier.
